operand_fetch: RTL and testbench

- Register-read side of the general-purpose register (GPR) file. The GPR write-back side writes R, F and M registers; this block reads them.
- Sits between decode and execute. It accepts one decoded instruction, drives the Gpr rs1/rs2/rs3 read ports and stalls on read-after-write (RAW) and write-after-write (WAW) hazards using a busy-bit scoreboard.
- Once the sources are clean, it registers the source operands and hands them to execute with a valid/ready handshake.
- The scoreboard clears each busy bit when the write-back stage commits that register.

---
 rtl/operand_fetch_pkg.sv | 27 ++
 rtl/operand_fetch_scoreboard.sv | 75 +++++++
 rtl/operand_fetch.sv | 222 ++++++++++++++++++++++
 tb/tb_operand_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// Module   : operand_fetch_pkg
// Purpose  : Register-group codes, datapath widths and operand-fetch states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

    localparam logic [1:0] REG_GROUP_R       = 2'd0;
    localparam logic [1:0] REG_GROUP_F       = 2'd1;
    localparam logic [1:0] REG_GROUP_M       = 2'd2;
    localparam logic [1:0] REG_GROUP_INVALID = 2'd3;

    localparam int GPR_R_W = 32;
    localparam int GPR_F_W = 32;
    localparam int GPR_M_W = 512;

    typedef enum logic [1:0] {
        OF_EMPTY = 2'd0,
        OF_WAIT  = 2'd1,
        OF_FULL  = 2'd2
    } of_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
// ============================================================================
// Module   : of_scoreboard
// Purpose  : Busy bits for the R/F/M register groups; 4 combinational queries,
//            one set and one clear port, set wins on a collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module of_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0][1:0] q_group,
    input  logic [3:0][4:0] q_index,
    output logic [3:0]      q_busy,
    input  logic            set_en,
    input  logic [1:0]      set_group,
    input  logic [4:0]      set_index,
    input  logic            clr_en,
    input  logic [1:0]      clr_group,
    input  logic [4:0]      clr_index
);

    logic [31:0] r_busy_r;
    logic [31:0] r_busy_f;
    logic [31:0] r_busy_m;

    function automatic logic [31:0] f_next(input logic [31:0] cur, input logic [1:0] grp,
                                           input logic s_en, input logic [1:0] s_grp,
                                           input logic [4:0] s_idx, input logic c_en,
                                           input logic [1:0] c_grp, input logic [4:0] c_idx);
        logic [31:0] v;
        v = cur;
        if (c_en && c_grp == grp) v = v & ~(32'd1 << c_idx);
        if (s_en && s_grp == grp) v = v | (32'd1 << s_idx);
        return v;
    endfunction

    function automatic logic f_lookup(input logic [1:0] grp, input logic [4:0] idx,
                                      input logic [31:0] br, input logic [31:0] bf,
                                      input logic [31:0] bm);
        logic b;
        case (grp)
            REG_GROUP_R: b = br[idx];
            REG_GROUP_F: b = bf[idx];
            REG_GROUP_M: b = bm[idx];
            default:     b = 1'b0;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy_r <= '0;
            r_busy_f <= '0;
            r_busy_m <= '0;
        end else begin
            // R0 is hardwired zero and therefore can never be pending
            r_busy_r <= f_next(r_busy_r, REG_GROUP_R, set_en, set_group, set_index,
                               clr_en, clr_group, clr_index) & 32'hFFFF_FFFE;
            r_busy_f <= f_next(r_busy_f, REG_GROUP_F, set_en, set_group, set_index,
                               clr_en, clr_group, clr_index);
            r_busy_m <= f_next(r_busy_m, REG_GROUP_M, set_en, set_group, set_index,
                               clr_en, clr_group, clr_index);
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_query
        assign q_busy[k] = f_lookup(q_group[k], q_index[k], r_busy_r, r_busy_f, r_busy_m);
    end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Purpose  : GPR read side between decode and execute; RAW/WAW stall on a
//            busy-bit scoreboard. OPERAND_FETCH_WB_BYPASS_EN forwards wb data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int CTRL_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               ready,
    input  logic [1:0]         id_rs1_group,
    input  logic [4:0]         id_rs1_index,
    input  logic [1:0]         id_rs2_group,
    input  logic [4:0]         id_rs2_index,
    input  logic [1:0]         id_rs3_group,
    input  logic [4:0]         id_rs3_index,
    input  logic [1:0]         id_rd_group,
    input  logic [4:0]         id_rd_index,
    input  logic [CTRL_W-1:0]  id_ctrl,
    output logic [1:0]         rs1_group,
    output logic [4:0]         rs1_index,
    output logic [1:0]         rs2_group,
    output logic [4:0]         rs2_index,
    output logic [1:0]         rs3_group,
    output logic [4:0]         rs3_index,
    input  logic [GPR_R_W-1:0] dout_R_rs1,
    input  logic [GPR_R_W-1:0] dout_R_rs2,
    input  logic [GPR_R_W-1:0] dout_R_rs3,
    input  logic [GPR_F_W-1:0] dout_F_rs1,
    input  logic [GPR_F_W-1:0] dout_F_rs2,
    input  logic [GPR_F_W-1:0] dout_F_rs3,
    input  logic [GPR_M_W-1:0] dout_M_rs1,
    input  logic [GPR_M_W-1:0] dout_M_rs2,
    input  logic [GPR_M_W-1:0] dout_M_rs3,
    input  logic               wb_we,
    input  logic [1:0]         wb_rd_group,
    input  logic [4:0]         wb_rd_index,
    input  logic [GPR_R_W-1:0] wb_R,
    input  logic [GPR_F_W-1:0] wb_F,
    input  logic [GPR_M_W-1:0] wb_M,
    output logic               valid,
    input  logic               EX_ready,
    output logic [GPR_R_W-1:0] src1_R,
    output logic [GPR_F_W-1:0] src1_F,
    output logic [GPR_M_W-1:0] src1_M,
    output logic [GPR_R_W-1:0] src2_R,
    output logic [GPR_F_W-1:0] src2_F,
    output logic [GPR_M_W-1:0] src2_M,
    output logic [GPR_R_W-1:0] src3_R,
    output logic [GPR_F_W-1:0] src3_F,
    output logic [GPR_M_W-1:0] src3_M,
    output logic [1:0]         rd_group,
    output logic [4:0]         rd_index,
    output logic [CTRL_W-1:0]  ctrl
);

    of_state_t r_state;
    of_state_t w_state_nxt;
    logic      w_latch;
    logic      w_issue;
    logic      w_hazard;

    logic [2:0][1:0]         r_id_src_group;
    logic [2:0][4:0]         r_id_src_index;
    logic [1:0]              r_id_rd_group;
    logic [4:0]              r_id_rd_index;
    logic [CTRL_W-1:0]       r_id_ctrl;

    logic [2:0][GPR_R_W-1:0] r_src_r;
    logic [2:0][GPR_F_W-1:0] r_src_f;
    logic [2:0][GPR_M_W-1:0] r_src_m;
    logic [1:0]              r_rd_group;
    logic [4:0]              r_rd_index;
    logic [CTRL_W-1:0]       r_ctrl;

    logic [2:0][GPR_R_W-1:0] w_dout_r;
    logic [2:0][GPR_F_W-1:0] w_dout_f;
    logic [2:0][GPR_M_W-1:0] w_dout_m;
    logic [2:0][GPR_R_W-1:0] w_src_r_nxt;
    logic [2:0][GPR_F_W-1:0] w_src_f_nxt;
    logic [2:0][GPR_M_W-1:0] w_src_m_nxt;

    logic [3:0][1:0]         w_q_group;
    logic [3:0][4:0]         w_q_index;
    logic [3:0]              w_busy;
    logic [3:0]              w_hit;

    // Query slots 0..2 are the sources, slot 3 is the destination
    assign w_q_group = {r_id_rd_group, r_id_src_group};
    assign w_q_index = {r_id_rd_index, r_id_src_index};

    assign w_dout_r = {dout_R_rs3, dout_R_rs2, dout_R_rs1};
    assign w_dout_f = {dout_F_rs3, dout_F_rs2, dout_F_rs1};
    assign w_dout_m = {dout_M_rs3, dout_M_rs2, dout_M_rs1};

    of_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .q_group   (w_q_group),
        .q_index   (w_q_index),
        .q_busy    (w_busy),
        .set_en    (w_issue),
        .set_group (r_id_rd_group),
        .set_index (r_id_rd_index),
        .clr_en    (wb_we),
        .clr_group (wb_rd_group),
        .clr_index (wb_rd_index)
    );

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    logic [3:0] w_match;
    for (genvar k = 0; k < 4; k++) begin : g_match
        assign w_match[k] = wb_we && (wb_rd_group != REG_GROUP_INVALID) &&
                            (wb_rd_group == w_q_group[k]) && (wb_rd_index == w_q_index[k]);
    end
    assign w_hit = w_busy & w_match;
`else
    assign w_hit = 4'b0000;
`endif

    assign w_hazard = |(w_busy & ~w_hit);

    for (genvar k = 0; k < 3; k++) begin : g_src_sel
        assign w_src_r_nxt[k] = (w_hit[k] && w_q_group[k] == REG_GROUP_R) ? wb_R : w_dout_r[k];
        assign w_src_f_nxt[k] = (w_hit[k] && w_q_group[k] == REG_GROUP_F) ? wb_F : w_dout_f[k];
        assign w_src_m_nxt[k] = (w_hit[k] && w_q_group[k] == REG_GROUP_M) ? wb_M : w_dout_m[k];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            OF_EMPTY: begin
                if (id_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = OF_WAIT;
                end
            end
            OF_WAIT: begin
                if (!w_hazard) begin
                    w_issue     = 1'b1;
                    w_state_nxt = OF_FULL;
                end
            end
            OF_FULL: begin
                if (EX_ready) begin
                    w_latch     = id_valid;
                    w_state_nxt = id_valid ? OF_WAIT : OF_EMPTY;
                end
            end
            default: w_state_nxt = OF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= OF_EMPTY;
            r_id_src_group <= '0;
            r_id_src_index <= '0;
            r_id_rd_group  <= '0;
            r_id_rd_index  <= '0;
            r_id_ctrl      <= '0;
            r_src_r        <= '0;
            r_src_f        <= '0;
            r_src_m        <= '0;
            r_rd_group     <= '0;
            r_rd_index     <= '0;
            r_ctrl         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_id_src_group <= {id_rs3_group, id_rs2_group, id_rs1_group};
                r_id_src_index <= {id_rs3_index, id_rs2_index, id_rs1_index};
                r_id_rd_group  <= id_rd_group;
                r_id_rd_index  <= id_rd_index;
                r_id_ctrl      <= id_ctrl;
            end
            if (w_issue) begin
                r_src_r    <= w_src_r_nxt;
                r_src_f    <= w_src_f_nxt;
                r_src_m    <= w_src_m_nxt;
                r_rd_group <= r_id_rd_group;
                r_rd_index <= r_id_rd_index;
                r_ctrl     <= r_id_ctrl;
            end
        end
    end

    assign ready = (r_state == OF_EMPTY) | ((r_state == OF_FULL) & EX_ready);
    assign valid = (r_state == OF_FULL);

    assign rs1_group = r_id_src_group[0];
    assign rs2_group = r_id_src_group[1];
    assign rs3_group = r_id_src_group[2];
    assign rs1_index = r_id_src_index[0];
    assign rs2_index = r_id_src_index[1];
    assign rs3_index = r_id_src_index[2];

    assign src1_R   = r_src_r[0];
    assign src2_R   = r_src_r[1];
    assign src3_R   = r_src_r[2];
    assign src1_F   = r_src_f[0];
    assign src2_F   = r_src_f[1];
    assign src3_F   = r_src_f[2];
    assign src1_M   = r_src_m[0];
    assign src2_M   = r_src_m[1];
    assign src3_M   = r_src_m[2];
    assign rd_group = r_rd_group;
    assign rd_index = r_rd_index;
    assign ctrl     = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Randomized self-checking bench for operand_fetch against a
//            pending-register reference model and a GPR array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int CTRL_W = 64;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    logic id_valid, ready;
    logic [1:0] id_rs1_group, id_rs2_group, id_rs3_group, id_rd_group;
    logic [4:0] id_rs1_index, id_rs2_index, id_rs3_index, id_rd_index;
    logic [CTRL_W-1:0] id_ctrl;
    logic [1:0] rs1_group, rs2_group, rs3_group;
    logic [4:0] rs1_index, rs2_index, rs3_index;
    logic [31:0] dout_R_rs1, dout_R_rs2, dout_R_rs3, dout_F_rs1, dout_F_rs2, dout_F_rs3;
    logic [511:0] dout_M_rs1, dout_M_rs2, dout_M_rs3;
    logic wb_we;
    logic [1:0] wb_rd_group;
    logic [4:0] wb_rd_index;
    logic [31:0] wb_R, wb_F;
    logic [511:0] wb_M;
    logic valid, EX_ready;
    logic [31:0] src1_R, src2_R, src3_R, src1_F, src2_F, src3_F;
    logic [511:0] src1_M, src2_M, src3_M;
    logic [1:0] rd_group;
    logic [4:0] rd_index;
    logic [CTRL_W-1:0] ctrl;

    // GPR file model and reference state
    logic [31:0]  gpr_r [32];
    logic [31:0]  gpr_f [32];
    logic [511:0] gpr_m [32];
    bit           pend [3][32];
    bit           m_hold, m_out;
    logic [1:0]   m_sg [3];
    logic [4:0]   m_si [3];
    logic [1:0]   m_dg;
    logic [4:0]   m_di;
    logic [CTRL_W-1:0] m_ctrl;
    logic [31:0]  e_r [3];
    logic [31:0]  e_f [3];
    logic [511:0] e_m [3];
    logic [1:0]   e_rd_g;
    logic [4:0]   e_rd_i;
    logic [CTRL_W-1:0] e_ctrl;

    int n_checks;
    int n_errors;

    operand_fetch #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .ready(ready),
        .id_rs1_group(id_rs1_group), .id_rs1_index(id_rs1_index),
        .id_rs2_group(id_rs2_group), .id_rs2_index(id_rs2_index),
        .id_rs3_group(id_rs3_group), .id_rs3_index(id_rs3_index),
        .id_rd_group(id_rd_group), .id_rd_index(id_rd_index), .id_ctrl(id_ctrl),
        .rs1_group(rs1_group), .rs1_index(rs1_index), .rs2_group(rs2_group),
        .rs2_index(rs2_index), .rs3_group(rs3_group), .rs3_index(rs3_index),
        .dout_R_rs1(dout_R_rs1), .dout_R_rs2(dout_R_rs2), .dout_R_rs3(dout_R_rs3),
        .dout_F_rs1(dout_F_rs1), .dout_F_rs2(dout_F_rs2), .dout_F_rs3(dout_F_rs3),
        .dout_M_rs1(dout_M_rs1), .dout_M_rs2(dout_M_rs2), .dout_M_rs3(dout_M_rs3),
        .wb_we(wb_we), .wb_rd_group(wb_rd_group), .wb_rd_index(wb_rd_index),
        .wb_R(wb_R), .wb_F(wb_F), .wb_M(wb_M),
        .valid(valid), .EX_ready(EX_ready),
        .src1_R(src1_R), .src1_F(src1_F), .src1_M(src1_M),
        .src2_R(src2_R), .src2_F(src2_F), .src2_M(src2_M),
        .src3_R(src3_R), .src3_F(src3_F), .src3_M(src3_M),
        .rd_group(rd_group), .rd_index(rd_index), .ctrl(ctrl)
    );

    assign dout_R_rs1 = gpr_r[rs1_index];
    assign dout_R_rs2 = gpr_r[rs2_index];
    assign dout_R_rs3 = gpr_r[rs3_index];
    assign dout_F_rs1 = gpr_f[rs1_index];
    assign dout_F_rs2 = gpr_f[rs2_index];
    assign dout_F_rs3 = gpr_f[rs3_index];
    assign dout_M_rs1 = gpr_m[rs1_index];
    assign dout_M_rs2 = gpr_m[rs2_index];
    assign dout_M_rs3 = gpr_m[rs3_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [1:0] rand_group();
        case ($urandom_range(0, 3))
            0:       return REG_GROUP_R;
            1:       return REG_GROUP_F;
            2:       return REG_GROUP_M;
            default: return REG_GROUP_INVALID;
        endcase
    endfunction

    function automatic logic [4:0] rand_index();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    function automatic bit is_busy(input logic [1:0] g, input logic [4:0] ix);
        if (g == REG_GROUP_INVALID) return 1'b0;
        return pend[g][ix];
    endfunction

    function automatic bit wb_frees(input logic [1:0] g, input logic [4:0] ix);
        return BYP && wb_we && (wb_rd_group == g) && (wb_rd_index == ix);
    endfunction

    // Inputs are already driven for this cycle; predict, clock, compare.
    task automatic step();
        bit hold0, out0, exp_ready, accept, issue, hz;
        logic [1:0] g;
        logic [4:0] ix;
        logic [31:0]  nr [3];
        logic [31:0]  nf [3];
        logic [511:0] nm [3];
        #1;
        hold0 = m_hold;
        out0  = m_out;
        exp_ready = (!hold0 && !out0) || (out0 && EX_ready);
        check_value("ready", ready, exp_ready);
        accept = exp_ready && id_valid;
        issue  = 1'b0;
        if (hold0) begin
            hz = 1'b0;
            for (int k = 0; k < 4; k++) begin
                g  = (k < 3) ? m_sg[k] : m_dg;
                ix = (k < 3) ? m_si[k] : m_di;
                if (is_busy(g, ix) && !wb_frees(g, ix)) hz = 1'b1;
            end
            issue = !hz;
            for (int k = 0; k < 3; k++) begin
                nr[k] = gpr_r[m_si[k]];
                nf[k] = gpr_f[m_si[k]];
                nm[k] = gpr_m[m_si[k]];
                if (is_busy(m_sg[k], m_si[k]) && wb_frees(m_sg[k], m_si[k])) begin
                    if (m_sg[k] == REG_GROUP_R) nr[k] = wb_R;
                    if (m_sg[k] == REG_GROUP_F) nf[k] = wb_F;
                    if (m_sg[k] == REG_GROUP_M) nm[k] = wb_M;
                end
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int a = 0; a < 3; a++) for (int b = 0; b < 32; b++) pend[a][b] = 1'b0;
            m_hold = 1'b0;
            m_out  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                e_r[k] = '0; e_f[k] = '0; e_m[k] = '0;
            end
            e_rd_g = '0; e_rd_i = '0; e_ctrl = '0;
        end else begin
            if (wb_we && wb_rd_group != REG_GROUP_INVALID) begin
                pend[wb_rd_group][wb_rd_index] = 1'b0;
                if (wb_rd_group == REG_GROUP_R && wb_rd_index != 5'd0) gpr_r[wb_rd_index] = wb_R;
                if (wb_rd_group == REG_GROUP_F) gpr_f[wb_rd_index] = wb_F;
                if (wb_rd_group == REG_GROUP_M) gpr_m[wb_rd_index] = wb_M;
            end
            if (issue) begin
                for (int k = 0; k < 3; k++) begin
                    e_r[k] = nr[k]; e_f[k] = nf[k]; e_m[k] = nm[k];
                end
                e_rd_g = m_dg; e_rd_i = m_di; e_ctrl = m_ctrl;
                if (m_dg != REG_GROUP_INVALID && !(m_dg == REG_GROUP_R && m_di == 5'd0))
                    pend[m_dg][m_di] = 1'b1;
            end
            m_out  = issue ? 1'b1 : ((out0 && EX_ready) ? 1'b0 : out0);
            m_hold = accept ? 1'b1 : (issue ? 1'b0 : hold0);
            if (accept) begin
                m_sg[0] = id_rs1_group; m_sg[1] = id_rs2_group; m_sg[2] = id_rs3_group;
                m_si[0] = id_rs1_index; m_si[1] = id_rs2_index; m_si[2] = id_rs3_index;
                m_dg = id_rd_group; m_di = id_rd_index; m_ctrl = id_ctrl;
            end
        end
        check_value("valid", valid, m_out);
        check_value("src1_R", src1_R, e_r[0]);
        check_value("src2_R", src2_R, e_r[1]);
        check_value("src3_R", src3_R, e_r[2]);
        check_value("src1_F", src1_F, e_f[0]);
        check_value("src2_F", src2_F, e_f[1]);
        check_value("src3_F", src3_F, e_f[2]);
        check_value("src1_M", src1_M, e_m[0]);
        check_value("src2_M", src2_M, e_m[1]);
        check_value("src3_M", src3_M, e_m[2]);
        check_value("rd_group", rd_group, e_rd_g);
        check_value("rd_index", rd_index, e_rd_i);
        check_value("ctrl", ctrl, e_ctrl);
        if (m_hold) begin
            check_value("rs1_group", rs1_group, m_sg[0]);
            check_value("rs2_group", rs2_group, m_sg[1]);
            check_value("rs3_group", rs3_group, m_sg[2]);
            check_value("rs1_index", rs1_index, m_si[0]);
            check_value("rs2_index", rs2_index, m_si[1]);
            check_value("rs3_index", rs3_index, m_si[2]);
        end
        @(negedge clk);
    endtask

    task automatic pick_wb();
        int cg[$];
        int ci[$];
        int sel, p;
        wb_we       = 1'b0;
        wb_rd_group = rand_group();
        wb_rd_index = rand_index();
        wb_R        = $urandom();
        wb_F        = $urandom();
        wb_M        = rand512();
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < 32; b++)
                    if (pend[a][b]) begin
                        cg.push_back(a);
                        ci.push_back(b);
                    end
            if (cg.size() > 0) begin
                p = $urandom_range(0, cg.size() - 1);
                wb_we       = 1'b1;
                wb_rd_group = 2'(cg[p]);
                wb_rd_index = 5'(ci[p]);
            end
        end else if (sel < 6) begin
            wb_we = 1'b1;
        end
    endtask

    task automatic set_inst(input logic [1:0] g1, input logic [4:0] i1,
                            input logic [1:0] dg, input logic [4:0] di);
        id_rs1_group = g1; id_rs1_index = i1;
        id_rs2_group = REG_GROUP_INVALID; id_rs2_index = 5'd0;
        id_rs3_group = REG_GROUP_INVALID; id_rs3_index = 5'd0;
        id_rd_group  = dg; id_rd_index  = di;
        id_ctrl      = {$urandom(), $urandom()};
    endtask

    initial begin
        bit fence;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) begin
            gpr_r[i] = (i == 0) ? 32'd0 : $urandom();
            gpr_f[i] = $urandom();
            gpr_m[i] = rand512();
        end
        gpr_r[5] = 32'h10;
        m_hold = 1'b0;
        m_out  = 1'b0;
        rst = 1'b0; id_valid = 1'b0; EX_ready = 1'b0;
        wb_we = 1'b0; wb_rd_group = REG_GROUP_INVALID; wb_rd_index = '0;
        wb_R = '0; wb_F = '0; wb_M = '0;
        set_inst(REG_GROUP_INVALID, 5'd0, REG_GROUP_INVALID, 5'd0);
        @(negedge clk);
        step();
        step();

        // addi R6 <- R5, then a RAW-dependent instruction on R6
        rst = 1'b1;
        id_valid = 1'b1;
        set_inst(REG_GROUP_R, 5'd5, REG_GROUP_R, 5'd6);
        step();
        id_valid = 1'b0;
        step();
        check_value("addi_valid", valid, 1'b1);
        check_value("addi_src1", src1_R, 32'h10);
        id_valid = 1'b1;
        set_inst(REG_GROUP_R, 5'd6, REG_GROUP_R, 5'd7);
        for (int i = 0; i < 5; i++) step();
        EX_ready = 1'b1;
        step();
        id_valid = 1'b0;
        step();
        step();
        check_value("raw_stalled", valid, 1'b0);
        wb_we = 1'b1; wb_rd_group = REG_GROUP_R; wb_rd_index = 5'd6; wb_R = 32'h20;
        step();
        wb_we = 1'b0;
        step();
        step();
        check_value("raw_src1", src1_R, 32'h20);

        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 249) != 0);
            id_valid = ($urandom_range(0, 3) != 0);
            fence    = ($urandom_range(0, 7) == 0);
            id_rs1_group = fence ? REG_GROUP_INVALID : rand_group();
            id_rs2_group = fence ? REG_GROUP_INVALID : rand_group();
            id_rs3_group = fence ? REG_GROUP_INVALID : rand_group();
            id_rd_group  = fence ? REG_GROUP_INVALID : rand_group();
            id_rs1_index = rand_index();
            id_rs2_index = rand_index();
            id_rs3_index = rand_index();
            id_rd_index  = rand_index();
            id_ctrl      = {$urandom(), $urandom()};
            EX_ready     = ($urandom_range(0, 3) != 0);
            pick_wb();
            if (!rst) wb_we = 1'b0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
